// File: rtl/apb_pll_cfg_bridge_pkg.sv
// Shared types and constants for the APB to PLL configuration bridge.
package pll_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word indices taken from PADDR[4:2]
  localparam logic [2:0] ADDR_REMOTE_FIRST = 3'd0;
  localparam logic [2:0] ADDR_REMOTE_LAST  = 3'd3;
  localparam logic [2:0] ADDR_STATUS       = 3'd4;

  localparam int LOCK_BIT = 0;
  localparam int LOL_BIT  = 1;

  function automatic logic is_remote(input logic [2:0] idx);
    return (idx >= ADDR_REMOTE_FIRST) && (idx <= ADDR_REMOTE_LAST);
  endfunction

endpackage

// File: rtl/apb_pll_cfg_bridge_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock, with a falling-edge pulse.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  output logic lock_s_o,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= lock_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign lock_s_o = r_sync;
  assign fall_o   = r_prev & ~r_sync;

endmodule

// File: rtl/apb_pll_cfg_bridge.sv
// APB3 slave driving the PLL req/ack config port and monitoring PLL lock.
// Optional REQ timeout abort is enabled by defining PLL_CFG_TIMEOUT_EN.
module apb_pll_cfg_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      cfg_req_o,
  input  logic                      cfg_ack_i,
  output logic [1:0]                cfg_add_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_wrn_o,
  input  logic [31:0]               cfg_r_data_i,
  input  logic                      cfg_lock_i,
  output logic                      irq_o
);

  import pll_cfg_pkg::*;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_start;

  logic [1:0]  r_cfg_add;
  logic [31:0] r_cfg_data;
  logic        r_cfg_wrn;
  logic [31:0] r_prdata;
  logic        r_lol;

  logic [2:0]  w_idx;
  logic        w_setup;
  logic        w_access;
  logic        w_remote;
  logic        w_local_acc;
  logic        w_status_sel;
  logic        w_lol_clr;
  logic        w_lock_s;
  logic        w_lock_fall;
  logic        w_tmo_err;
  logic [31:0] w_status;
  logic        w_unused_addr;

  assign w_idx         = PADDR[4:2];
  assign w_setup       = PSEL & ~PENABLE;
  assign w_access      = PSEL & PENABLE;
  assign w_remote      = is_remote(w_idx);
  assign w_status_sel  = (w_idx == ADDR_STATUS);
  // Local registers answer with zero wait states, but only while no remote transfer is in flight
  assign w_local_acc   = w_access & ~w_remote & (r_state == IDLE);
  assign w_lol_clr     = w_local_acc & PWRITE & w_status_sel & PWDATA[LOL_BIT];
  assign w_unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  always_comb begin
    w_status           = '0;
    w_status[LOCK_BIT] = w_lock_s;
    w_status[LOL_BIT]  = r_lol;
  end

  pll_lock_sync u_lock_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .lock_i   (cfg_lock_i),
    .lock_s_o (w_lock_s),
    .fall_o   (w_lock_fall)
  );

`ifdef PLL_CFG_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_err = r_tmo_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if ((r_state == REQ) && !cfg_ack_i) begin
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_err    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    cfg_req_o    = 1'b0;
    PREADY       = 1'b0;
    PSLVERR      = 1'b0;
    PRDATA       = '0;

    case (r_state)
      IDLE: begin
        if (w_setup && w_remote) begin
          w_state_next = REQ;
          w_start      = 1'b1;
        end
        if (w_local_acc) begin
          PREADY  = 1'b1;
          PSLVERR = ~w_status_sel;
          if (w_status_sel && !PWRITE) begin
            PRDATA = w_status;
          end
        end
      end
      REQ: begin
        cfg_req_o = 1'b1;
        // Ack is a level: the first high sample ends the transfer, no wait for it to fall
        if (cfg_ack_i) begin
          w_state_next = DONE;
        end
`ifdef PLL_CFG_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_next = DONE;
        end
`endif
      end
      DONE: begin
        PREADY       = 1'b1;
        PSLVERR      = w_tmo_err;
        PRDATA       = r_prdata;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg_add  <= '0;
      r_cfg_data <= '0;
      r_cfg_wrn  <= 1'b0;
      r_prdata   <= '0;
    end else if (w_start) begin
      r_cfg_add  <= PADDR[3:2];
      r_cfg_data <= PWDATA;
      r_cfg_wrn  <= ~PWRITE;
      r_prdata   <= '0;
    end else if ((r_state == REQ) && cfg_ack_i) begin
      r_prdata <= r_cfg_wrn ? cfg_r_data_i : 32'd0;
    end
  end

  // A fall seen in the same cycle as a W1C clear must not be lost
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lol <= 1'b0;
    end else if (w_lock_fall) begin
      r_lol <= 1'b1;
    end else if (w_lol_clr) begin
      r_lol <= 1'b0;
    end
  end

  assign cfg_add_o  = r_cfg_add;
  assign cfg_data_o = r_cfg_data;
  assign cfg_wrn_o  = r_cfg_wrn;
  assign irq_o      = r_lol;

endmodule

// File: tb/tb_apb_pll_cfg_bridge.sv
// Directed bench for apb_pll_cfg_bridge with an APB scoreboard and a PLL ack responder.
`timescale 1ns/1ps
module tb_apb_pll_cfg_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        cfg_req_o;
  logic        cfg_ack_i;
  logic [1:0]  cfg_add_o;
  logic [31:0] cfg_data_o;
  logic        cfg_wrn_o;
  logic [31:0] cfg_r_data_i;
  logic        cfg_lock_i;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  apb_pll_cfg_bridge #(
    .APB_ADDR_WIDTH (12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .cfg_req_o    (cfg_req_o),
    .cfg_ack_i    (cfg_ack_i),
    .cfg_add_o    (cfg_add_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_wrn_o    (cfg_wrn_o),
    .cfg_r_data_i (cfg_r_data_i),
    .cfg_lock_i   (cfg_lock_i),
    .irq_o        (irq_o)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // PLL responder: 0 = ack after ack_delay request cycles, 1 = ack tied high, 2 = never ack
  int ack_mode  = 0;
  int ack_delay = 3;
  int rq_cnt    = 0;
  int req_total = 0;

  always @(negedge clk_i) begin
    if (cfg_req_o) req_total++;
    case (ack_mode)
      1: cfg_ack_i = 1'b1;
      2: cfg_ack_i = 1'b0;
      default: begin
        if (cfg_req_o) begin
          rq_cnt++;
          cfg_ack_i = (rq_cnt >= ack_delay);
        end else begin
          rq_cnt    = 0;
          cfg_ack_i = 1'b0;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input string tag, input logic [11:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                     output int waits, output int reqs);
    exp_t e;
    int   base;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    base = req_total;
    @(negedge clk_i);
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk_i);
    PENABLE = 1'b1;
    #1;
    waits = 0;
    while (!PREADY && waits < 64) begin
      @(negedge clk_i);
      #1;
      waits++;
    end
    e = sb_q.pop_front();
    if (!PREADY) begin
      check({tag, " pready_timeout"}, {31'b0, PREADY}, 32'd1);
    end else begin
      check({tag, " prdata"}, PRDATA, e.rdata);
      check({tag, " pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
    end
    reqs = req_total - base;
    $display("txn %s addr=%h wr=%0d wdata=%h rdata=%h err=%0d waits=%0d req_cycles=%0d",
             tag, addr, wr, wdata, PRDATA, PSLVERR, waits, reqs);
    @(negedge clk_i);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  int w, r;

  initial begin
    rst_i = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    cfg_r_data_i = 32'h1234_5678; cfg_lock_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst pready",  {31'b0, PREADY},    32'd0);
    check("rst pslverr", {31'b0, PSLVERR},   32'd0);
    check("rst prdata",  PRDATA,             32'd0);
    check("rst req",     {31'b0, cfg_req_o}, 32'd0);
    check("rst add",     {30'b0, cfg_add_o}, 32'd0);
    check("rst data",    cfg_data_o,         32'd0);
    check("rst wrn",     {31'b0, cfg_wrn_o}, 32'd0);
    check("rst irq",     {31'b0, irq_o},     32'd0);
    rst_i = 1'b0;

    // Remote write, ack on the third request cycle
    ack_mode = 0; ack_delay = 3;
    apb("wr_remote", 12'h004, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, w, r);
    check("wr add",   {30'b0, cfg_add_o}, 32'd1);
    check("wr data",  cfg_data_o,         32'hDEAD_BEEF);
    check("wr wrn",   {31'b0, cfg_wrn_o}, 32'd0);
    check("wr req_cycles", r, 32'd3);
    check("wr waits", w, 32'd3);

    // Remote read with ack permanently high
    ack_mode = 1;
    apb("rd_remote", 12'h00C, 1'b0, 32'h0, 32'h1234_5678, 1'b0, w, r);
    check("rd add",   {30'b0, cfg_add_o}, 32'd3);
    check("rd wrn",   {31'b0, cfg_wrn_o}, 32'd1);
    check("rd req_cycles", r, 32'd1);
    check("rd waits", w, 32'd1);

    // Lock rise, then loss of lock, then W1C clear
    cfg_lock_i = 1'b1;
    repeat (4) @(negedge clk_i);
    apb("status_locked", 12'h010, 1'b0, 32'h0, 32'h1, 1'b0, w, r);
    check("status_locked waits", w, 32'd0);
    check("irq locked", {31'b0, irq_o}, 32'd0);
    cfg_lock_i = 1'b0;
    repeat (4) @(negedge clk_i);
    apb("status_lol", 12'h010, 1'b0, 32'h0, 32'h2, 1'b0, w, r);
    check("irq lol", {31'b0, irq_o}, 32'd1);
    apb("status_w1c", 12'h010, 1'b1, 32'h2, 32'h0, 1'b0, w, r);
    apb("status_clear", 12'h010, 1'b0, 32'h0, 32'h0, 1'b0, w, r);
    check("irq cleared", {31'b0, irq_o}, 32'd0);

    // Lock fall coincides with the W1C access cycle: set must win
    cfg_lock_i = 1'b1;
    repeat (4) @(negedge clk_i);
    @(negedge clk_i);
    cfg_lock_i = 1'b0;
    apb("w1c_race", 12'h010, 1'b1, 32'h2, 32'h0, 1'b0, w, r);
    apb("status_race", 12'h010, 1'b0, 32'h0, 32'h2, 1'b0, w, r);
    check("irq race", {31'b0, irq_o}, 32'd1);
    apb("w1c_after_race", 12'h010, 1'b1, 32'h2, 32'h0, 1'b0, w, r);
    check("irq after race", {31'b0, irq_o}, 32'd0);

    // Unmapped local addresses
    apb("bad_wr_18", 12'h018, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, w, r);
    check("bad18 waits", w, 32'd0);
    check("bad18 req_cycles", r, 32'd0);
    apb("bad_rd_14", 12'h014, 1'b0, 32'h0, 32'h0, 1'b1, w, r);
    check("bad14 req_cycles", r, 32'd0);

`ifdef PLL_CFG_TIMEOUT_EN
    ack_mode = 2;
    apb("timeout", 12'h008, 1'b0, 32'h0, 32'h0, 1'b1, w, r);
    check("timeout req_cycles", r, 32'd8);
    check("timeout waits", w, 32'd8);
`endif

    // Reset while a remote transfer is stuck in REQ
    ack_mode = 2;
    @(negedge clk_i);
    PADDR = 12'h008; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk_i);
    PENABLE = 1'b1;
    @(negedge clk_i);
    #1;
    check("midreq req", {31'b0, cfg_req_o}, 32'd1);
    check("midreq pready", {31'b0, PREADY}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_midreq req", {31'b0, cfg_req_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    $display("txn rst_midreq addr=008 abandoned");

    ack_mode = 1;
    cfg_r_data_i = 32'hA5A5_0F0F;
    apb("rd_after_rst", 12'h000, 1'b0, 32'h0, 32'hA5A5_0F0F, 1'b0, w, r);
    check("after_rst waits", w, 32'd1);
    check("after_rst add", {30'b0, cfg_add_o}, 32'd0);

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_pll_cfg_bridge.md
Name: apb_pll_cfg_bridge

Overview:
- APB3 slave that sits directly upstream of the FPGA PLL wrapper and drives its req/ack configuration port (cfg_req, cfg_ack, cfg_add, cfg_data, cfg_r_data, cfg_wrn).
- Also monitors the PLL lock output: synchronises it, exposes it in a local status register, and records loss of lock.
- Lets SoC software read and write the PLL configuration and lock state over the peripheral bus without knowing the handshake.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR; only bits [4:2] are decoded.
- TIMEOUT_CYCLES, 256, maximum cycles in REQ before the transfer is aborted (used only with PLL_CFG_TIMEOUT_EN).

Ports:
- clk_i  in  1  bridge clock; same clock as the PLL config port.
- rst_i  in  1  synchronous, active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB direction; 1 = write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- cfg_req_o  out  1  PLL config request.
- cfg_ack_i  in  1  PLL config acknowledge, level-sensitive.
- cfg_add_o  out  2  PLL register index.
- cfg_data_o  out  32  PLL write data.
- cfg_wrn_o  out  1  0 = write, 1 = read.
- cfg_r_data_i  in  32  PLL read data.
- cfg_lock_i  in  1  PLL lock, asynchronous to clk_i.
- irq_o  out  1  loss-of-lock interrupt, level.

Behaviour:
- Reset (rst_i = 1, sampled on the clk_i edge): all outputs 0; FSM to IDLE; lock synchroniser flops 0; sticky LOL bit 0.
- Address decode on PADDR[4:2]:
  - 0..3: remote PLL registers; cfg_add_o = PADDR[3:2].
  - 4: STATUS. Bit0 = synchronised lock (read-only). Bit1 = sticky loss-of-lock (LOL); writing 1 clears it.
  - 5..7: PREADY = 1, PSLVERR = 1, PRDATA = 0; no side effect.
- Local access (addresses 4..7): zero wait states; PREADY = 1 combinationally in the access phase.
- FSM for remote access, states IDLE, REQ, DONE:
  - IDLE -> REQ on a setup phase (PSEL & ~PENABLE) to a remote address. On that edge, register cfg_add_o, cfg_data_o = PWDATA and cfg_wrn_o = ~PWRITE.
  - REQ: cfg_req_o = 1, PREADY = 0. On the first cycle cfg_ack_i = 1, register PRDATA = cfg_r_data_i (reads only; writes leave PRDATA = 0), drop cfg_req_o, go to DONE.
  - DONE: PREADY = 1 for exactly one cycle, PSLVERR = 0, then IDLE.
  - Minimum remote latency: setup cycle + 1 REQ cycle + DONE, so PREADY rises 2 cycles after the setup edge.
- ACK handling: cfg_ack_i is level-sensitive and may stay high permanently. The bridge does not wait for it to fall. Each transfer is terminated by the first high ack sampled while in REQ.
- A new setup phase is never accepted outside IDLE; APB serialises transfers.
- Lock synchronisation:
  - 2-flop synchroniser on cfg_lock_i gives lock_s.
  - LOL sets when lock_s falls (1 -> 0) and the previous lock_s was 1.
  - irq_o = LOL.
  - If a set event and a W1C clear happen in the same cycle, set wins.
- Reset asserted in REQ: cfg_req_o drops the same edge and the APB transfer is abandoned. The PLL sees the request vanish; this is acceptable.

Optional Feature:
- Macro: PLL_CFG_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If it reaches TIMEOUT_CYCLES - 1 without ack, go to DONE with PSLVERR = 1, PRDATA = 0, cfg_req_o dropped.
  - The counter clears on entry to REQ.
- Undefined: REQ waits indefinitely; no counter logic.

Decomposition:
- Package pll_cfg_pkg holds:
  - the FSM state enum (IDLE, REQ, DONE);
  - address offsets ADDR_STATUS = 3'd4 and the remote range;
  - STATUS bit positions LOCK_BIT = 0, LOL_BIT = 1.
- One sub-module: pll_lock_sync (2-flop synchroniser with edge detect, output lock_s and fall pulse).

Test Plan:
- Write PADDR 0x004, PWDATA 0xDEADBEEF, ack returned 3 cycles after req -> cfg_add_o = 1, cfg_data_o = 0xDEADBEEF, cfg_wrn_o = 0; cfg_req_o high exactly 3 cycles; PREADY one cycle after ack; PSLVERR = 0.
- Read PADDR 0x00C with cfg_r_data_i = 0x12345678 and ack tied high -> cfg_wrn_o = 1; cfg_req_o high 1 cycle; PRDATA = 0x12345678; PREADY 2 cycles after setup.
- Drive cfg_lock_i 0 -> 1 -> 0 -> read STATUS gives 0x1 while locked; after the fall, 0x2 and irq_o = 1; write 0x2 to 0x010 -> STATUS 0x0, irq_o = 0.
- Lock falls in the same cycle as the W1C write to STATUS -> LOL stays 1.
- Access PADDR 0x018 -> PREADY = 1, PSLVERR = 1, PRDATA = 0, cfg_req_o never asserted.
- With PLL_CFG_TIMEOUT_EN, TIMEOUT_CYCLES = 8, ack held 0 -> PSLVERR = 1 after 8 REQ cycles. Then assert rst_i mid-REQ on a second transfer -> cfg_req_o = 0 on the next edge and the FSM returns to IDLE.
